lsu_exec: RTL and testbench
===========================

# lsu_exec

Load/store execution unit at the consumer end of the memory reservation-station queue. It takes the single in-order load or store at the queue head and computes the address `val_i + imm_i`. Stores commit to a private data memory the same cycle. Loads read the memory, wait a fixed latency, then broadcast the result on the LW result bus (`we_LW`/`tag_LW`/`val_LW`) back to all reservation stations. `stop` holds the queue head while a load is in flight.

## Interface
- `DEPTH`, 1024: data memory size in 32-bit words; power of two.
- `LD_LAT`, 2: load latency in cycles from acceptance to broadcast; ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lw_i`  in  1  queue head is a load with ready operands.
- `sw_i`  in  1  queue head is a store with ready operands.
- `dst_i`  in  5  architectural destination register of the load.
- `dst_tag_i`  in  5  rename tag of the load result.
- `imm_i`  in  32  address offset.
- `val_i`  in  32  base-address operand.
- `data_i`  in  32  store data; ignored for loads.
- `stop`  out  1  load in flight; the queue must hold a load at its head.
- `we_LW`  out  1  load result valid, one-cycle pulse.
- `tag_LW`  out  5  tag of the broadcast result.
- `dst_LW`  out  5  destination register of the broadcast result.
- `val_LW`  out  32  loaded word.
- `misalign`  out  1  sticky misaligned-access flag (see Configuration).

## Operation
- Address `addr = val_i + imm_i`, modulo 2^32. Word index is `addr[log2(DEPTH)+1:2]`; higher bits wrap silently.
- Store: on any edge with `sw_i=1`, `mem[idx] <= data_i`. Stores are never blocked by `stop`, because the queue pops stores regardless of `stop`.
- Load acceptance: an edge with `lw_i & ~stop`.
  - Registers `mem[idx]` into the result register, and latches `dst_i`/`dst_tag_i`.
  - Sets `busy` and loads `cnt <= LD_LAT-1`.
- A load that arrives while `stop=1` is ignored. The queue re-presents it until `stop` drops.
- FSM states: IDLE (`busy=0`) and WAIT (`busy=1`).
  - IDLE → WAIT on load acceptance.
  - In WAIT, each edge:
    - if `cnt==0`: `we_LW <= 1` and go to IDLE;
    - otherwise `cnt <= cnt-1`.
- `stop = busy`, driven from a register; no combinational path from the inputs.
- `we_LW` is high for exactly one cycle per accepted load. `tag_LW`, `dst_LW` and `val_LW` hold their values until the next broadcast.
- Memory is read at acceptance. A store presented while the load waits does not change the loaded value, which preserves queue program order.
- `lw_i & sw_i` together is a protocol violation; the store is performed and the load is not accepted.

## Timing
- Reset values: `stop=0`, `we_LW=0`, `tag_LW=0`, `dst_LW=0`, `val_LW=0`, `misalign=0`, state IDLE, `cnt=0`.
- Memory contents are not reset.
- Load accepted at edge E0 → `we_LW` high in the cycle after edge E(LD_LAT).
- `stop` is high from after E0 through the cycle ending at E(LD_LAT).
- Next load can be accepted at E(LD_LAT+1). Load throughput is one per LD_LAT+1 cycles.
- Store: the write is visible to a load accepted at the following edge.
- Reset during WAIT: the pending load is dropped, no broadcast occurs, and `stop` is 0 the cycle after the reset edge.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined:
  - An access with `addr[1:0] != 0` sets `misalign` (cleared only by `rst`).
  - A misaligned store is suppressed.
  - A misaligned load still completes, using the truncated word index.
- `LSU_MISALIGN_CHK_EN` undefined: `misalign` is tied 0 and the low address bits are ignored.

## Structure
- Package `lsu_pkg` holds `TAG_W=5`, `REG_W=5`, `DATA_W=32` and the FSM state enum (IDLE, WAIT).
- Sub-module `lsu_dmem`: single-port, synchronous-read, synchronous-write RAM of `DEPTH`×32, with write enable and read enable.
- Address generation, FSM, counter and broadcast register live in `lsu_exec`.

## Test plan
- Store, then load, LD_LAT=2:
  - Store with `val_i=0x100`, `imm_i=4`, `data_i=0xDEADBEEF`.
  - Next cycle, load with `val_i=0x104`, `imm_i=0`, `dst_tag_i=7`.
  - Expect `we_LW` 2 cycles after acceptance with `tag_LW=7`, `val_LW=0xDEADBEEF`.
- Back-to-back loads held by `stop`, LD_LAT=2:
  - Hold `lw_i=1` with two distinct tags.
  - Expect the second acceptance exactly 3 cycles after the first and two single-cycle `we_LW` pulses.
- Store during WAIT:
  - Load address 0x20 (contents 0x11), then store 0x22 to address 0x20 while `stop=1`.
  - Expect `val_LW=0x11` for the load; a later load of 0x20 returns 0x22.
- Wrap-around, DEPTH=1024:
  - Store to `addr=0x1000` (index 0).
  - Load with `val_i=0`, `imm_i=0` → the stored value.
- Reset mid-load:
  - Assert `rst` one cycle after acceptance.
  - Expect no `we_LW`, `stop=0`, all outputs 0.
- Misalignment, with `LSU_MISALIGN_CHK_EN` defined:
  - Store to `addr=0x102` → memory unchanged and `misalign=1`, held until `rst`.
  - Without the macro, `misalign` stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared widths and FSM state type for the load/store execution unit.
package lsu_pkg;
  localparam int TAG_W  = 5;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;
endpackage

// File: rtl/lsu_dmem.sv
// Single-port data RAM, synchronous write and synchronous read.
// rdata_o holds its value until the next read enable.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/lsu_exec.sv
// Load/store execution unit: address generation, load-latency FSM and LW
// result broadcast. Define LSU_MISALIGN_CHK_EN for misaligned-access checking.
module lsu_exec
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int LD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lw_i,
  input  logic              sw_i,
  input  logic [REG_W-1:0]  dst_i,
  input  logic [TAG_W-1:0]  dst_tag_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] val_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              stop,
  output logic              we_LW,
  output logic [TAG_W-1:0]  tag_LW,
  output logic [REG_W-1:0]  dst_LW,
  output logic [DATA_W-1:0] val_LW,
  output logic              misalign,
  output lsu_state_e        dbg_state_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LD_LAT > 1) ? $clog2(LD_LAT) : 1;

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  ld_tag_q, tag_lw_q;
  logic [REG_W-1:0]  ld_dst_q, dst_lw_q;
  logic [DATA_W-1:0] val_lw_q, rdata;
  logic              we_lw_q, bcast;
  logic [DATA_W-1:0] addr;
  logic [AW-1:0]     idx;
  logic              mis, acc_ld, mem_we;
  logic              addr_unused;

  assign addr        = val_i + imm_i;
  assign idx         = addr[AW+1:2];
  assign addr_unused = ^{addr[DATA_W-1:AW+2], addr[1:0]};

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign_q;
  assign mis = (addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (mis && (sw_i || acc_ld)) begin
      misalign_q <= 1'b1;
    end
  end
  assign misalign = misalign_q;
`else
  assign mis      = 1'b0;
  assign misalign = 1'b0;
`endif

  // A simultaneous lw_i/sw_i is a protocol violation: the store wins.
  assign acc_ld = lw_i & ~sw_i & (state_q == IDLE);
  assign mem_we = sw_i & ~mis;

  lsu_dmem #(.DEPTH(DEPTH)) u_dmem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (acc_ld),
    .addr_i  (idx),
    .wdata_i (data_i),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcast   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc_ld) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          bcast   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_lw_q  <= 1'b0;
      ld_tag_q <= '0;
      ld_dst_q <= '0;
      tag_lw_q <= '0;
      dst_lw_q <= '0;
      val_lw_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_lw_q <= bcast;
      if (acc_ld) begin
        ld_tag_q <= dst_tag_i;
        ld_dst_q <= dst_i;
      end
      // Read data was captured at acceptance, so later stores cannot alter it.
      if (bcast) begin
        tag_lw_q <= ld_tag_q;
        dst_lw_q <= ld_dst_q;
        val_lw_q <= rdata;
      end
    end
  end

  assign stop        = (state_q == WAIT);
  assign we_LW       = we_lw_q;
  assign tag_LW      = tag_lw_q;
  assign dst_LW      = dst_lw_q;
  assign val_LW      = val_lw_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_lsu_exec.sv
// Scoreboard bench for lsu_exec (DEPTH=1024, LD_LAT=2); honours LSU_MISALIGN_CHK_EN.
module tb_lsu_exec;
  import lsu_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int LD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, lw_i, sw_i;
  logic [4:0]  dst_i, dst_tag_i;
  logic [31:0] imm_i, val_i, data_i;
  logic        stop, we_LW, misalign;
  logic [4:0]  tag_LW, dst_LW;
  logic [31:0] val_LW;
  lsu_state_e  dbg_state;

  lsu_exec #(.DEPTH(DEPTH), .LD_LAT(LD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .lw_i        (lw_i),
    .sw_i        (sw_i),
    .dst_i       (dst_i),
    .dst_tag_i   (dst_tag_i),
    .imm_i       (imm_i),
    .val_i       (val_i),
    .data_i      (data_i),
    .stop        (stop),
    .we_LW       (we_LW),
    .tag_LW      (tag_LW),
    .dst_LW      (dst_LW),
    .val_LW      (val_LW),
    .misalign    (misalign),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [57:0] exp_q[$];  // {broadcast cycle[15:0], tag, dst, value}
  logic [31:0] mem_m [DEPTH];
  int          model_next = 0;  // earliest edge number that can accept a load
  logic        misalign_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] idx_of(input logic [31:0] v, input logic [31:0] i);
    logic [31:0] a;
    a = v + i;
    return a[11:2];
  endfunction

  function automatic logic mis_of(input logic [31:0] v, input logic [31:0] i);
    logic [31:0] a;
    a = v + i;
`ifdef LSU_MISALIGN_CHK_EN
    return (a[1:0] != 2'b00);
`else
    return (a[1:0] == 2'b00) && 1'b0;
`endif
  endfunction

  // One cycle: advance to the negedge and check everything the model predicts.
  task automatic tick();
    logic [57:0] e;
    @(negedge clk);
    check("stop", stop, (cyc < model_next - 1));
    check("misalign", misalign, misalign_m);
    if (we_LW) begin
      if (exp_q.size() == 0) begin
        check("we_LW_spurious", we_LW, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("bcast_cycle", cyc, e[57:42]);
        check("tag_LW", tag_LW, e[41:37]);
        check("dst_LW", dst_LW, e[36:32]);
        check("val_LW", val_LW, e[31:0]);
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][57:42]) <= cyc) begin
      e = exp_q.pop_front();
      check("we_LW_missing", we_LW, 1'b1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    lw_i = 1'b0;
    sw_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    lw_i = 1'b0;
    sw_i = 1'b0;
    exp_q.delete();
    model_next = 0;
    misalign_m = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] v, input logic [31:0] i, input logic [31:0] d);
    lw_i = 1'b0;
    val_i = v; imm_i = i; data_i = d; sw_i = 1'b1;
    if (mis_of(v, i)) misalign_m = 1'b1;
    else mem_m[idx_of(v, i)] = d;
    tick();
    sw_i = 1'b0;
  endtask

  // Holds lw_i until the model says the DUT accepts; leaves lw_i asserted.
  task automatic do_load(input logic [31:0] v, input logic [31:0] i,
                         input logic [4:0] dst, input logic [4:0] tag);
    val_i = v; imm_i = i; dst_i = dst; dst_tag_i = tag; lw_i = 1'b1;
    while (cyc + 1 < model_next) tick();
    exp_q.push_back({16'(cyc + 1 + LD_LAT), tag, dst, mem_m[idx_of(v, i)]});
    model_next = cyc + 2 + LD_LAT;
    if (mis_of(v, i)) misalign_m = 1'b1;
    tick();
  endtask

  // Load and store presented together: only the store takes effect.
  task automatic do_both(input logic [31:0] v, input logic [31:0] d);
    val_i = v; imm_i = 32'h0; data_i = d; dst_i = 5'd9; dst_tag_i = 5'd9;
    lw_i = 1'b1; sw_i = 1'b1;
    mem_m[idx_of(v, 32'h0)] = d;
    tick();
    lw_i = 1'b0; sw_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a, b, d;
    rst = 1'b1; lw_i = 1'b0; sw_i = 1'b0;
    dst_i = '0; dst_tag_i = '0; imm_i = '0; val_i = '0; data_i = '0;
    do_reset(2);
    check("rst_we_LW", we_LW, 1'b0);
    check("rst_tag_LW", tag_LW, 5'd0);
    check("rst_dst_LW", dst_LW, 5'd0);
    check("rst_val_LW", val_LW, 32'd0);
    check("rst_state", dbg_state, IDLE);

    // Store then load of the same word on the next edge.
    do_store(32'h100, 32'd4, 32'hDEADBEEF);
    do_load(32'h104, 32'd0, 5'd3, 5'd7);
    idle(4);

    // Back-to-back loads held by stop.
    do_store(32'h200, 32'd0, 32'hA5A5_0001);
    do_store(32'h1F0, 32'h14, 32'h5A5A_0002);
    do_load(32'h200, 32'd0, 5'd1, 5'd1);
    do_load(32'h204, 32'd0, 5'd2, 5'd2);
    idle(5);

    // Store during WAIT does not affect the in-flight load.
    do_store(32'h20, 32'd0, 32'h11);
    do_load(32'h20, 32'd0, 5'd4, 5'd4);
    do_store(32'h20, 32'd0, 32'h22);
    idle(4);
    do_load(32'h10, 32'h10, 5'd5, 5'd5);
    idle(4);

    // Word index wraps above DEPTH words; address adder wraps at 2^32.
    do_store(32'h1000, 32'd0, 32'hCAFE_0000);
    do_load(32'h0, 32'h0, 5'd6, 5'd8);
    idle(4);
    do_store(32'hFFFF_FFFC, 32'd8, 32'h0BAD_F00D);
    do_load(32'h4, 32'h0, 5'd7, 5'd9);
    idle(4);

    // Simultaneous load and store: store performed, load ignored.
    do_both(32'h40, 32'h7777_1234);
    idle(3);
    do_load(32'h40, 32'd0, 5'd8, 5'd10);
    idle(4);

    // Reset one cycle after acceptance drops the pending load.
    do_load(32'h104, 32'd0, 5'd3, 5'd12);
    idle(1);
    do_reset(1);
    check("midrst_stop", stop, 1'b0);
    check("midrst_we_LW", we_LW, 1'b0);
    check("midrst_tag_LW", tag_LW, 5'd0);
    check("midrst_dst_LW", dst_LW, 5'd0);
    check("midrst_val_LW", val_LW, 32'd0);
    check("midrst_state", dbg_state, IDLE);
    idle(4);

    // Misaligned store (suppressed only with the checker enabled).
    do_store(32'h100, 32'd0, 32'h1234_5678);
    do_store(32'h100, 32'd2, 32'h0000_0055);
    idle(3);
    do_load(32'h100, 32'd0, 5'd11, 5'd13);
    idle(6);
    do_reset(1);

    // Random aligned traffic over a small window.
    for (int k = 0; k < 8; k++) do_store(32'h300 + 32'(k * 4), 32'd0, $urandom);
    for (int k = 0; k < 30; k++) begin
      a = 32'h300 + 32'($urandom_range(0, 7) * 4);
      b = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_store(b, a - b, d);
      end else begin
        do_load(b, a - b, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        idle($urandom_range(0, 2));
      end
    end
    idle(6);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
